noc_output_allocator: RTL and testbench
=======================================

# noc_output_allocator

Per-output-port switch allocator for the 5-port mesh router. It arbitrates round-robin among the router's input ports competing for one output port. It holds the grant for a whole packet, from head flit to tail flit, so packets are never interleaved. It also tracks credits for the downstream input buffer, so a flit is only granted when the neighbour can accept it. Each router instantiates one allocator per output port (east, west, south, north, local), between the input buffers and the output crossbar select.

## Interface
Parameters:
- PORT_NUM, 5: number of requesting input ports, indexed {0 east, 1 west, 2 south, 3 north, 4 local}.
- CREDIT_DEPTH, 4: downstream buffer depth in flits; the initial and maximum credit count.
- CREDIT_W, $clog2(CREDIT_DEPTH+1): width of the credit counter.

Ports:
- noc_clk, input, 1: clock. One clock only.
- noc_rst_n, input, 1: reset, asynchronous, active-low.
- req, input, PORT_NUM: input port i has a flit at its buffer head destined for this output.
- flit_kind, input, PORT_NUM x 2: kind of the head-of-buffer flit per input, type Noc_flit_kind.
- grant, output, PORT_NUM: one-hot or zero. The granted input transfers its flit this cycle.
- grant_valid, output, 1: OR of grant. Drives the crossbar output-valid.
- credit_return, input, 1: the downstream buffer freed one slot.
- credit_cnt, output, CREDIT_W: current credits available.
- locked, output, 1: a packet currently owns the port.
- err, output, 1: sticky protocol error flag. Cleared only by reset.

## Operation
- State machine, 2 states:
  - IDLE: no packet owns the port.
  - LOCKED: the owner register holds the packet's input index.
- Grant eligibility:
  - IDLE: eligible inputs are those with req=1 and kind HEAD or SINGLE.
  - LOCKED: only the owner is eligible, and only while req[owner]=1.
- Grant rule: grant is asserted only when credit_cnt>0. In IDLE, the winner is the first eligible input searching upward from rr_ptr, wrapping at PORT_NUM-1 to 0.
- Transfer: any cycle with grant_valid=1 is a transfer. There is no separate accept handshake; upstream must dequeue that cycle.
- IDLE transitions:
  - HEAD transfer: go to LOCKED, owner=winner.
  - SINGLE transfer: stay IDLE, rr_ptr=winner+1 (mod PORT_NUM).
- LOCKED transitions:
  - BODY transfer: stay LOCKED.
  - TAIL transfer: go to IDLE, rr_ptr=owner+1 (mod PORT_NUM).
  - Owner presents HEAD or SINGLE: set err, transfer anyway, treat the flit as TAIL.
- Requests from input j ≠ owner while LOCKED are held off. grant[j] stays 0 and no error is raised.
- An IDLE request with kind BODY or TAIL is never granted and sets err.
- Credit counter:
  - Transfer only: decrement.
  - credit_return only: increment.
  - Both in the same cycle: unchanged.
  - credit_return while credit_cnt==CREDIT_DEPTH and no transfer: set err, hold at CREDIT_DEPTH, never wrap.
  - The counter never underflows, because grant requires credit_cnt>0.

## Timing
- Reset values: state IDLE, owner 0, rr_ptr 0, credit_cnt=CREDIT_DEPTH, err 0, locked 0, grant 0, grant_valid 0.
- Grant is combinational from registered state (state, owner, rr_ptr, credit_cnt) and current req/flit_kind. Latency is 0 cycles from request to grant.
- State, owner, rr_ptr, credit_cnt and err update on the rising noc_clk edge after the transfer cycle.
- Throughput is one flit per cycle while credits last. Back-to-back packets from different inputs need no bubble: the TAIL cycle and the next HEAD grant are consecutive cycles.
- A credit returned in cycle t becomes usable for a grant in cycle t+1.
- Reset mid-packet aborts ownership immediately and restores full credits. Upstream and downstream are reset by the same noc_rst_n.
- locked is registered and equals (state==LOCKED).

## Structure
- Package Noc_parameters gains:
  - typedef enum logic [1:0] Noc_flit_kind {HEAD=2'b00, BODY=2'b01, TAIL=2'b10, SINGLE=2'b11}.
  - localparam Noc_Port_Num=5.
  - localparam Noc_Credit_Depth, used as the default for CREDIT_DEPTH.
- One sub-module: noc_rr_arbiter. It is a purely combinational parameterised round-robin priority picker with inputs (request vector, pointer) and outputs (one-hot grant, winner index). It is reused by the VC allocator later. The FSM and the credit counter stay in noc_output_allocator.

## Test plan
- Single-flit contention: all 5 req with SINGLE, credits 4, no credit_return. Grants go to inputs 0,1,2,3 on consecutive cycles, then grant_valid=0 with credit_cnt=0. One credit_return then grants input 4.
- Packet lock: input 2 sends HEAD,BODY,BODY,TAIL while input 0 requests HEAD throughout, with credit_return asserted every cycle. Grants are 2,2,2,2, then input 0 on the next cycle. locked is high for exactly 3 cycles, and credit_cnt holds at 4.
- Credit stall mid-packet: credit_cnt reaches 0 after HEAD plus 3 BODY flits. Grant drops and the allocator stays LOCKED. A credit_return in cycle t gives grant to the owner in cycle t+1, with credit_cnt 1→0.
- Round-robin fairness: inputs 1 and 3 each send continuous SINGLE flits, with unlimited credit_return. Grants alternate 1,3,1,3.
- Protocol errors: BODY from input 4 while IDLE is never granted and sets err. credit_return at credit_cnt=4 sets err and credit_cnt stays 4.
- Async reset while LOCKED with credit_cnt=1: asserting noc_rst_n low immediately gives grant=0, locked=0 and credit_cnt=4, with no clock edge required.

Source files
------------

// File: rtl/noc_output_allocator_pkg.sv
// Shared types for the mesh router output allocator.
// Flit kinds, allocator states and default sizing.
package Noc_parameters;

  typedef enum logic [1:0] {
    HEAD   = 2'b00,
    BODY   = 2'b01,
    TAIL   = 2'b10,
    SINGLE = 2'b11
  } Noc_flit_kind;

  typedef enum logic {
    IDLE   = 1'b0,
    LOCKED = 1'b1
  } Noc_alloc_state;

  localparam int Noc_Port_Num     = 5;
  localparam int Noc_Credit_Depth = 4;

  function automatic logic is_start(
    input logic [1:0] k
  );
    return (k == HEAD) || (k == SINGLE);
  endfunction

endpackage

// File: rtl/noc_rr_arbiter.sv
// Combinational round-robin picker.
// Searches upward from ptr, wrapping at N-1.
module noc_rr_arbiter #(
  parameter int N = 5,
  parameter int W = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0] req,
  input  logic [W-1:0] ptr,
  output logic [N-1:0] gnt,
  output logic [W-1:0] idx
);

  logic         found;
  logic [W-1:0] k;

  always_comb begin
    gnt   = '0;
    idx   = '0;
    found = 1'b0;
    k     = '0;
    for (int i = 0; i < N; i++) begin
      k = W'((int'(ptr) + i) % N);
      if (!found && req[k]) begin
        found  = 1'b1;
        gnt[k] = 1'b1;
        idx    = k;
      end
    end
  end

endmodule

// File: rtl/noc_output_allocator.sv
// Per-output switch allocator: packet-locked
// round-robin grant gated by downstream credits.
module noc_output_allocator
  import Noc_parameters::*;
#(
  parameter int PORT_NUM     = Noc_Port_Num,
  parameter int CREDIT_DEPTH = Noc_Credit_Depth,
  parameter int CREDIT_W     = $clog2(CREDIT_DEPTH + 1)
) (
  input  logic                     noc_clk,
  input  logic                     noc_rst_n,
  input  logic [PORT_NUM-1:0]      req,
  input  logic [PORT_NUM-1:0][1:0] flit_kind,
  output logic [PORT_NUM-1:0]      grant,
  output logic                     grant_valid,
  input  logic                     credit_return,
  output logic [CREDIT_W-1:0]      credit_cnt,
  output logic                     locked,
  output logic                     err
);

  localparam int IW = (PORT_NUM > 1) ? $clog2(PORT_NUM) : 1;
  localparam logic [IW-1:0] LAST = IW'(PORT_NUM - 1);
  localparam logic [CREDIT_W-1:0] CMAX = CREDIT_W'(CREDIT_DEPTH);

  Noc_alloc_state state_q, state_n;

  logic [IW-1:0]       owner_q, owner_n;
  logic [IW-1:0]       rr_q, rr_n;
  logic [IW-1:0]       win;
  logic [CREDIT_W-1:0] credit_q, credit_n;
  logic                err_q, err_n;
  logic [PORT_NUM-1:0] start_req;
  logic [PORT_NUM-1:0] bad_req;
  logic [PORT_NUM-1:0] arb_gnt;
  logic [PORT_NUM-1:0] grant_c;
  logic [1:0]          kind;
  logic                xfer;

  function automatic logic [IW-1:0] wrap_inc(
    input logic [IW-1:0] i
  );
    return (i == LAST) ? '0 : i + 1'b1;
  endfunction

  always_comb begin
    start_req = '0;
    bad_req   = '0;
    for (int i = 0; i < PORT_NUM; i++) begin
      start_req[i] = req[i] && is_start(flit_kind[i]);
      bad_req[i]   = req[i] && !is_start(flit_kind[i]);
    end
  end

  noc_rr_arbiter #(
    .N (PORT_NUM),
    .W (IW)
  ) u_arb (
    .req (start_req),
    .ptr (rr_q),
    .gnt (arb_gnt),
    .idx (win)
  );

  // Grant is forced low while reset is held, not just after it.
  always_comb begin
    grant_c = '0;
    if (noc_rst_n && (credit_q != '0)) begin
      if (state_q == IDLE) grant_c = arb_gnt;
      else grant_c[owner_q] = req[owner_q];
    end
  end

  assign xfer = |grant_c;
  assign kind = (state_q == IDLE) ? flit_kind[win]
                                  : flit_kind[owner_q];

  always_comb begin
    state_n  = state_q;
    owner_n  = owner_q;
    rr_n     = rr_q;
    err_n    = err_q;
    credit_n = credit_q;
    unique case (state_q)
      IDLE: begin
        if (|bad_req) err_n = 1'b1;
        if (xfer) begin
          if (kind == HEAD) begin
            state_n = LOCKED;
            owner_n = win;
          end else begin
            rr_n = wrap_inc(win);
          end
        end
      end
      LOCKED: begin
        // A stray HEAD/SINGLE from the owner closes the packet.
        if (xfer && (kind != BODY)) begin
          state_n = IDLE;
          rr_n    = wrap_inc(owner_q);
          if (is_start(kind)) err_n = 1'b1;
        end
      end
      default: state_n = IDLE;
    endcase
    case ({xfer, credit_return})
      2'b10: credit_n = credit_q - 1'b1;
      2'b01: begin
        if (credit_q == CMAX) err_n = 1'b1;
        else credit_n = credit_q + 1'b1;
      end
      default: credit_n = credit_q;
    endcase
  end

  always_ff @(posedge noc_clk or negedge noc_rst_n) begin
    if (!noc_rst_n) begin
      state_q  <= IDLE;
      owner_q  <= '0;
      rr_q     <= '0;
      credit_q <= CMAX;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_n;
      owner_q  <= owner_n;
      rr_q     <= rr_n;
      credit_q <= credit_n;
      err_q    <= err_n;
    end
  end

  assign grant       = grant_c;
  assign grant_valid = xfer;
  assign credit_cnt  = credit_q;
  assign locked      = (state_q == LOCKED);
  assign err         = err_q;

endmodule

// File: tb/tb_noc_output_allocator.sv
// Scoreboard bench for noc_output_allocator.
// Expected per-cycle outputs queued at drive time.
module tb_noc_output_allocator;

  localparam logic [1:0] H = 2'b00;
  localparam logic [1:0] B = 2'b01;
  localparam logic [1:0] T = 2'b10;
  localparam logic [1:0] S = 2'b11;

  logic       clk   = 1'b0;
  logic       rst_n = 1'b1;
  logic [4:0] req   = '0;
  logic [9:0] kv    = '0;
  logic       cr    = 1'b0;
  logic [4:0] grant;
  logic       grant_valid;
  logic [2:0] credit_cnt;
  logic       locked;
  logic       err;

  typedef struct packed {
    logic [4:0] g;
    logic [2:0] c;
    logic       l;
    logic       e;
  } exp_t;

  exp_t sb[$];
  exp_t cur;
  int   n_vec = 0;
  int   n_bad = 0;

  always #5 clk = ~clk;

  noc_output_allocator dut (
    .noc_clk       (clk),
    .noc_rst_n     (rst_n),
    .req           (req),
    .flit_kind     (kv),
    .grant         (grant),
    .grant_valid   (grant_valid),
    .credit_return (cr),
    .credit_cnt    (credit_cnt),
    .locked        (locked),
    .err           (err)
  );

  task automatic expect_eq(
    input string       tag,
    input logic [31:0] got,
    input logic [31:0] want
  );
    n_vec++;
    if (got !== want) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h at %0t",
               tag, got, want, $time);
    end
  endtask

  always @(negedge clk) begin
    if (sb.size() > 0) begin
      cur = sb.pop_front();
      expect_eq("grant", 32'(grant), 32'(cur.g));
      expect_eq("gvalid", 32'(grant_valid), 32'(|cur.g));
      expect_eq("credit", 32'(credit_cnt), 32'(cur.c));
      expect_eq("locked", 32'(locked), 32'(cur.l));
      expect_eq("err", 32'(err), 32'(cur.e));
    end
  end

  task automatic step(
    input logic [4:0] r,
    input logic [9:0] k,
    input logic       c,
    input logic [4:0] eg,
    input int         ec,
    input logic       el,
    input logic       ee
  );
    exp_t x;
    @(posedge clk);
    #1;
    req = r;
    kv  = k;
    cr  = c;
    x.g = eg;
    x.c = 3'(ec);
    x.l = el;
    x.e = ee;
    sb.push_back(x);
  endtask

  initial begin
    req = '1;
    kv  = {5{S}};
    #1 rst_n = 1'b0;
    #2;
    expect_eq("rst_grant", 32'(grant), 32'h0);
    expect_eq("rst_gvalid", 32'(grant_valid), 32'h0);
    expect_eq("rst_locked", 32'(locked), 32'h0);
    expect_eq("rst_credit", 32'(credit_cnt), 32'h4);
    expect_eq("rst_err", 32'(err), 32'h0);
    req = '0;
    #9 rst_n = 1'b1;

    // single-flit contention until credits run out
    step(5'b11111, {5{S}}, 0, 5'b00001, 4, 0, 0);
    step(5'b11111, {5{S}}, 0, 5'b00010, 3, 0, 0);
    step(5'b11111, {5{S}}, 0, 5'b00100, 2, 0, 0);
    step(5'b11111, {5{S}}, 0, 5'b01000, 1, 0, 0);
    step(5'b11111, {5{S}}, 0, 5'b00000, 0, 0, 0);
    step(5'b11111, {5{S}}, 1, 5'b00000, 0, 0, 0);
    step(5'b11111, {5{S}}, 0, 5'b10000, 1, 0, 0);
    for (int i = 0; i < 4; i++)
      step(5'b00000, {5{S}}, 1, 5'b00000, i, 0, 0);

    // packet lock against a competing HEAD
    step(5'b00010, {5{S}}, 1, 5'b00010, 4, 0, 0);
    step(5'b00101, {5{H}}, 1, 5'b00100, 4, 0, 0);
    step(5'b00101, {H, H, B, H, H}, 1, 5'b00100, 4, 1, 0);
    step(5'b00101, {H, H, B, H, H}, 1, 5'b00100, 4, 1, 0);
    step(5'b00101, {H, H, T, H, H}, 1, 5'b00100, 4, 1, 0);
    step(5'b00001, {5{H}}, 0, 5'b00001, 4, 0, 0);

    // credit stall mid-packet
    step(5'b00001, {5{B}}, 0, 5'b00001, 3, 1, 0);
    step(5'b00001, {5{B}}, 0, 5'b00001, 2, 1, 0);
    step(5'b00001, {5{B}}, 0, 5'b00001, 1, 1, 0);
    step(5'b00001, {5{B}}, 1, 5'b00000, 0, 1, 0);
    step(5'b00001, {5{B}}, 0, 5'b00001, 1, 1, 0);
    step(5'b00001, {5{T}}, 1, 5'b00000, 0, 1, 0);
    step(5'b00001, {5{T}}, 0, 5'b00001, 1, 1, 0);
    for (int i = 0; i < 4; i++)
      step(5'b00000, {5{S}}, 1, 5'b00000, i, 0, 0);

    // round-robin fairness
    step(5'b01010, {5{S}}, 1, 5'b00010, 4, 0, 0);
    step(5'b01010, {5{S}}, 1, 5'b01000, 4, 0, 0);
    step(5'b01010, {5{S}}, 1, 5'b00010, 4, 0, 0);
    step(5'b01010, {5{S}}, 1, 5'b01000, 4, 0, 0);

    // credit overflow
    step(5'b00000, {5{S}}, 1, 5'b00000, 4, 0, 0);
    step(5'b00000, {5{S}}, 0, 5'b00000, 4, 0, 1);

    // lock input 3 down to one credit, then reset
    step(5'b01000, {5{H}}, 0, 5'b01000, 4, 0, 1);
    step(5'b01000, {5{B}}, 0, 5'b01000, 3, 1, 1);
    step(5'b01000, {5{B}}, 0, 5'b01000, 2, 1, 1);
    @(posedge clk);
    #1;
    req = 5'b01000;
    kv  = {5{B}};
    cr  = 1'b0;
    #1;
    expect_eq("pre_grant", 32'(grant), 32'h08);
    expect_eq("pre_credit", 32'(credit_cnt), 32'h1);
    expect_eq("pre_locked", 32'(locked), 32'h1);
    rst_n = 1'b0;
    #1;
    expect_eq("arst_grant", 32'(grant), 32'h0);
    expect_eq("arst_gvalid", 32'(grant_valid), 32'h0);
    expect_eq("arst_locked", 32'(locked), 32'h0);
    expect_eq("arst_credit", 32'(credit_cnt), 32'h4);
    expect_eq("arst_err", 32'(err), 32'h0);
    req = '0;
    #1 rst_n = 1'b1;

    // BODY while idle
    step(5'b10000, {5{B}}, 0, 5'b00000, 4, 0, 0);
    step(5'b10000, {5{B}}, 0, 5'b00000, 4, 0, 1);
    step(5'b00000, {5{S}}, 0, 5'b00000, 4, 0, 1);

    @(posedge clk);
    @(negedge clk);
    #1;
    expect_eq("drain", 32'(sb.size()), 32'h0);
    $display("== %0d vectors applied, %0d miscompares ==",
             n_vec, n_bad);
    $finish;
  end

endmodule
